// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch/decode constants: datapath width, NOP encoding, opcode fields, queue entry width.
package if_fetch_queue_pkg;
  localparam int          FQ_XLEN    = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;

  function automatic int entry_w(input int xlen);
    return xlen + 32;
  endfunction
endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous FIFO, registered head, 1-cycle push-to-head latency; flush beats push/pop.
// No internal overflow protection: the producer must honour full/count.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so the natural pointer overflow is the mod-DEPTH wrap.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_q];
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC, 1-cycle imem requests, {pc,inst} queue to decode; fetch-to-decode 2 cycles.
// Requests stop once queued + in-flight entries would exceed DEPTH; redirects flush everything.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = FQ_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst
);
  localparam int EW  = entry_w(XLEN);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   count;
  logic [CW1-1:0]  credit;
  logic [EW-1:0]   head;
  logic            empty, full, pop, push, issue;
  logic            unused_sig;

  assign pop = id_valid & id_ready;
  // The in-flight response owns a slot, so a stalled queue can never be overrun.
  assign credit = {1'b0, count} + CW1'(pend_q) - CW1'(pop);
  assign issue  = ~rst & ~redirect_valid & (credit < CW1'(DEPTH));
  assign push   = pend_q & ~redirect_valid;

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign id_valid  = ~empty & ~redirect_valid;
  assign id_pc     = empty ? '0 : head[EW-1:32];
  assign id_inst   = empty ? '0 : head[31:0];

  always_comb begin
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      pc_d      = pc_q + XLEN'(4);
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pend_pc_q, imem_rdata}),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  assign unused_sig = ^{full, redirect_pc[1:0]};
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: next address to fetch, next PC decode should see,
  // fetches issued but not yet delivered, and whether one was issued last cycle.
  logic [31:0] m_fetch = RPC;
  logic [31:0] m_deliver = RPC;
  int          m_out = 0;
  int          m_prev_iss = 0;
  bit          m_prev_rst = 1'b0;

  if_fetch_queue #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  always #5 clk = ~clk;

  // Instruction memory with a fixed 1-cycle read latency; junk when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ SALT;
    else         imem_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    int ev, ep, ee;
    @(negedge clk);
    if (rst) begin
      chk("rst_imem_en", 32'(imem_en), 32'd0);
      if (m_prev_rst) begin
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
      end
      m_fetch = RPC; m_deliver = RPC; m_out = 0; m_prev_iss = 0;
    end else if (redirect_valid) begin
      chk("redir_imem_en", 32'(imem_en), 32'd0);
      chk("redir_id_valid", 32'(id_valid), 32'd0);
      m_fetch = redirect_pc & ~32'd3;
      m_deliver = m_fetch;
      m_out = 0; m_prev_iss = 0;
    end else begin
      ev = ((m_out - m_prev_iss) > 0) ? 1 : 0;
      ep = (ev != 0 && id_ready) ? 1 : 0;
      ee = ((m_out - ep) < DEPTH) ? 1 : 0;
      chk("id_valid", 32'(id_valid), 32'(ev));
      chk("imem_en", 32'(imem_en), 32'(ee));
      if (ev != 0) begin
        chk("id_pc", id_pc, m_deliver);
        chk("id_inst", id_inst, m_deliver ^ SALT);
      end
      if (ee != 0) begin
        chk("imem_addr", imem_addr, m_fetch);
        m_fetch = m_fetch + 32'd4;
      end
      if (ep != 0) m_deliver = m_deliver + 32'd4;
      m_out = m_out + ee - ep;
      m_prev_iss = ee;
      chk("fifo_count_bound", 32'(dut.u_fifo.count <= DEPTH), 32'd1);
    end
    m_prev_rst = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then free-running fetch with decode always ready.
    rst = 1'b1; id_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0; id_ready = 1'b1;
    repeat (10) cyc();

    // Decode stall: queue fills, fetch stops, head holds; then drain in order.
    id_ready = 1'b0;
    repeat (6) cyc();
    id_ready = 1'b1;
    repeat (6) cyc();

    // Redirect with a full queue and a response in flight; low bits are dropped.
    id_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    cyc();
    redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (8) cyc();

    // Back-to-back redirects: only the second stream survives.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    redirect_pc = 32'h0000_0300;
    cyc();
    redirect_valid = 1'b0;
    repeat (8) cyc();

    // Reset with a full queue: restart at RESET_PC.
    id_ready = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0; id_ready = 1'b1;
    repeat (6) cyc();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    repeat (6) cyc();

    // Randomised mix of stalls, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = $urandom;
      id_ready       = ($urandom_range(0, 99) < 70);
      cyc();
    end
    rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
